// File: rtl/tmp_pkg.sv
// rtl/tmp_pkg.sv - shared types, defaults and helpers for the temperature decoder
package tmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } tmp_dec_state_t;

    localparam int TMP_N_PHASES = 256;
    localparam int TMP_ACC_W    = 11;

    // Shift a two's complement accumulator into offset binary; callers keep the low acc_w bits
    function automatic logic [15:0] to_offset_bin(input logic [15:0] acc, input int unsigned acc_w);
        return acc + (16'd1 << (acc_w - 1));
    endfunction

endpackage

// File: rtl/tmp_updown_acc.sv
// rtl/tmp_updown_acc.sv - signed saturating up/down accumulator with clear and clip flag
module tmp_updown_acc #(
    parameter int W = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                up,
    input  logic                dn,
    output logic signed [W-1:0] acc,
    output logic                sat
);

    // Symmetric limits: the most negative code is never used so the range is +-(2^(W-1)-1)
    localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    // Count one step per cycle; simultaneous up and down cancel, clipping latches sat until clear
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (up && !dn) begin
            if (acc == ACC_MAX) begin
                sat <= 1'b1;
            end else begin
                acc <= acc + ONE;
            end
        end else if (dn && !up) begin
            if (acc == ACC_MIN) begin
                sat <= 1'b1;
            end else begin
                acc <= acc - ONE;
            end
        end
    end

endmodule

// File: rtl/tmp_decoder.sv
// rtl/tmp_decoder.sv - accumulates src/snk pulses over PI2 windows into an offset-binary code
module tmp_decoder
    import tmp_pkg::*;
#(
    parameter int N_PHASES = TMP_N_PHASES,
    parameter int ACC_W    = TMP_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preChrg,
    input  logic             PI2,
    input  logic             src_n,
    input  logic             snk,
    output logic [ACC_W-1:0] code,
    output logic             code_valid,
    output logic             busy,
    output logic             sat,
    output logic             contention
);

    localparam logic [11:0]      PHASE_LAST = 12'(N_PHASES - 1);
    localparam logic [ACC_W-1:0] CODE_ZERO  = {1'b1, {(ACC_W-1){1'b0}}};

    tmp_dec_state_t state, next_state;

    logic pre_r1, pre_r2, pi2_r1, pi2_r2, src_n_r1, snk_r1;
    logic [11:0] phase_cnt;
    logic start, pi2_fall, count_en, up, dn;
    logic signed [ACC_W-1:0] acc;
    logic acc_sat;

    // Input registers; preChrg and PI2 get a second stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r1   <= 1'b0;
            pre_r2   <= 1'b0;
            pi2_r1   <= 1'b0;
            pi2_r2   <= 1'b0;
            src_n_r1 <= 1'b1;
            snk_r1   <= 1'b0;
        end else begin
            pre_r1   <= preChrg;
            pre_r2   <= pre_r1;
            pi2_r1   <= PI2;
            pi2_r2   <= pi2_r1;
            src_n_r1 <= src_n;
            snk_r1   <= snk;
        end
    end

    // While preChrg is high PI2 activity is ignored entirely, so a restart always beats a final window edge
    assign start    = pre_r1 && !pre_r2;
    assign pi2_fall = !pi2_r1 && pi2_r2 && !pre_r1;
    assign count_en = (state == ACCUM) && pi2_r1 && !pre_r1;
    assign up       = count_en && !src_n_r1;
    assign dn       = count_en && snk_r1;

    tmp_updown_acc #(
        .W(ACC_W)
    ) u_acc (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .up    (up),
        .dn    (dn),
        .acc   (acc),
        .sat   (acc_sat)
    );

    // Next-state logic: any preChrg rising edge (re)starts a conversion
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = ACCUM;
            end
            ACCUM: begin
                if (start) begin
                    next_state = ACCUM;
                end else if (pi2_fall && phase_cnt == PHASE_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = start ? ACCUM : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register, phase counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            busy       <= 1'b0;
            code_valid <= 1'b0;
            code       <= CODE_ZERO;
            sat        <= 1'b0;
            contention <= 1'b0;
        end else begin
            state      <= next_state;
            code_valid <= 1'b0;
            if (state == DONE) begin
                code       <= ACC_W'(to_offset_bin(16'(acc), ACC_W));
                sat        <= acc_sat;
                code_valid <= 1'b1;
                busy       <= 1'b0;
            end
            if (start) begin
                phase_cnt  <= '0;
                busy       <= 1'b1;
                contention <= 1'b0;
            end else if (state == ACCUM) begin
                if (pi2_fall) phase_cnt <= phase_cnt + 12'd1;
                if (up && dn) contention <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tmp_decoder.sv
// tb/tb_tmp_decoder.sv - self-checking bench for tmp_decoder against a pulse-count model
module tb_tmp_decoder;

    localparam int N  = 4;
    localparam int WA = 11;
    localparam int WB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, preChrg = 1'b0, PI2 = 1'b0, src_n = 1'b1, snk = 1'b0;
    logic [WA-1:0] a_code;
    logic [WB-1:0] b_code;
    logic a_valid, a_busy, a_sat, a_cont;
    logic b_valid, b_busy, b_sat, b_cont;

    tmp_decoder #(.N_PHASES(N), .ACC_W(WA)) dut_a (
        .clk(clk), .reset(reset), .preChrg(preChrg), .PI2(PI2), .src_n(src_n), .snk(snk),
        .code(a_code), .code_valid(a_valid), .busy(a_busy), .sat(a_sat), .contention(a_cont)
    );

    tmp_decoder #(.N_PHASES(N), .ACC_W(WB)) dut_b (
        .clk(clk), .reset(reset), .preChrg(preChrg), .PI2(PI2), .src_n(src_n), .snk(snk),
        .code(b_code), .code_valid(b_valid), .busy(b_busy), .sat(b_sat), .contention(b_cont)
    );

    int n_pass = 0;
    int n_total = 0;

    int m_acc [2];
    bit m_sat [2];
    bit m_cont;
    bit alt;
    int widths [2] = '{WA, WB};

    function automatic int offset(input int acc, input int w);
        return (acc + (1 << (w - 1))) & ((1 << w) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_sat[i] = 1'b0;
        end
        m_cont = 1'b0;
        alt = 1'b0;
    endtask

    // One counted cycle: +1 for a source, -1 for a sink, clamp to the symmetric range
    task automatic model_cycle(input bit sn, input bit sk);
        int delta, lim, t;
        delta = (sn ? 0 : 1) - (sk ? 1 : 0);
        if (!sn && sk) m_cont = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lim = (1 << (widths[i] - 1)) - 1;
            t = m_acc[i] + delta;
            if (t > lim) begin t = lim; m_sat[i] = 1'b1; end
            if (t < -lim) begin t = -lim; m_sat[i] = 1'b1; end
            m_acc[i] = t;
        end
    endtask

    task automatic step(input bit p, input bit pi, input bit sn, input bit sk, input bit counted, input bit exp_valid);
        preChrg = p; PI2 = pi; src_n = sn; snk = sk;
        if (counted) model_cycle(sn, sk);
        @(posedge clk); #1;
        chk("a_code_valid", a_valid, exp_valid);
        chk("b_code_valid", b_valid, exp_valid);
    endtask

    task automatic check_reset();
        chk("rst_a_code", a_code, 1 << (WA - 1));
        chk("rst_b_code", b_code, 1 << (WB - 1));
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_cont", a_cont, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_sat", b_sat, 0);
    endtask

    // preChrg high for three cycles, with a PI2 pulse carrying contention that must be ignored
    task automatic preamble(input bit fresh);
        model_reset();
        step(1, 0, 1, 0, 0, 0);
        if (fresh) chk("busy_before_2clk", a_busy, 0);
        step(1, 1, 0, 1, 0, 0);
        chk("busy_at_2clk", a_busy, 1);
        chk("cont_cleared", a_cont, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic window(input int mode, input int len, input bit last);
        bit sn, sk;
        for (int c = 0; c < len; c++) begin
            case (mode)
                0: begin sn = 1'b0; sk = 1'b0; end
                1: begin sn = 1'b1; sk = 1'b1; end
                2: begin alt = ~alt; sn = !alt; sk = !alt; end
                3: begin sn = 1'($urandom); sk = 1'($urandom); end
                default: begin sn = 1'b0; sk = (c == 0); end
            endcase
            step(0, 1, sn, sk, 1, 0);
        end
        if (!last) step(0, 0, 1'($urandom), 1'($urandom), 0, 0);
    endtask

    // After the final PI2 fall the strobe must appear on exactly the third clock
    task automatic finish_conv();
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1'($urandom), 1'($urandom), 0, i == 3);
            if (i == 2) chk("busy_before_done", a_busy, 1);
            if (i == 3 || i == 5) begin
                chk("a_code", a_code, offset(m_acc[0], WA));
                chk("a_sat", a_sat, m_sat[0]);
                chk("b_code", b_code, offset(m_acc[1], WB));
                chk("b_sat", b_sat, m_sat[1]);
                chk("busy_after_done", a_busy, 0);
                chk("contention", a_cont, m_cont);
            end
        end
    endtask

    task automatic conv(input int m0, input int m1, input int m2, input int m3, input int len, input bit fresh);
        preamble(fresh);
        window(m0, len, 0);
        window(m1, len, 0);
        window(m2, len, 0);
        window(m3, len, 1);
        finish_conv();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        reset = 1'b0;

        conv(0, 0, 0, 0, 3, 1);
        chk("src_only_code", a_code, 1036);
        chk("sat_clip_code", b_code, 15);
        chk("sat_clip_flag", b_sat, 1);

        conv(1, 1, 1, 1, 3, 1);
        chk("snk_only_code", a_code, 1012);

        conv(2, 2, 2, 2, 3, 1);
        chk("balanced_code", a_code, 1024);

        conv(0, 4, 0, 0, 3, 1);
        chk("contention_code", a_code, 1035);
        chk("contention_flag", a_cont, 1);

        for (int i = 0; i < 12; i++) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        chk("idle_busy", a_busy, 0);
        chk("idle_code_hold", a_code, 1035);
        chk("idle_cont_sticky", a_cont, 1);

        preamble(1);
        window(3, 3, 0);
        window(3, 3, 0);
        chk("abort_code_hold", a_code, 1035);
        conv(3, 3, 3, 3, 3, 0);

        repeat (3) conv($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(1, 4), 1);

        preamble(1);
        window(0, 2, 0);
        window(0, 2, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0, 1'($urandom), 1'($urandom), 0, 0);
        chk("post_reset_busy", a_busy, 0);

        conv(3, 3, 3, 3, 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
